// File: rtl/controle_jogo.sv
// controle_jogo
// Game-control sequencer for the naval-battle board. Owns the mode FSM
// (off / preparation / attack / end), registers map selection and attack
// coordinates from the switches, tracks lives, hits and already-attacked
// cells, and generates the digit-scan counter for the display multiplexer.
//
// Ports:
//   clock, reset_n          system clock, asynchronous active-low reset
//   botao_liga              power button (debounced, synchronous)
//   botao_confirma          confirm button (debounced, synchronous)
//   chaves_coluna/linha     attack coordinate switches (3 bits each)
//   chaves_mapa             map-select switches (2 bits)
//   celula_ocupada          external lookup of (mapa, coordLinha, coordColuna)
//   contador                2-bit digit-scan index
//   ATAQUE/PREPARACAO/DESLIGADO  mode flags, exactly one high
//   coordColuna/coordLinha  registered attack coordinates
//   mapa                    registered map selection
//   vida                    remaining lives
//   vitoria/derrota         end-of-game result flags
module controle_jogo #(
    parameter int DIV_REFRESH  = 50000,
    parameter int VIDA_INICIAL = 5,
    parameter int ALVOS        = 4
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       botao_liga,
    input  logic       botao_confirma,
    input  logic [2:0] chaves_coluna,
    input  logic [2:0] chaves_linha,
    input  logic [1:0] chaves_mapa,
    input  logic       celula_ocupada,
    output logic [1:0] contador,
    output logic       ATAQUE,
    output logic       PREPARACAO,
    output logic       DESLIGADO,
    output logic [2:0] coordColuna,
    output logic [2:0] coordLinha,
    output logic [1:0] mapa,
    output logic [2:0] vida,
    output logic       vitoria,
    output logic       derrota
);

    localparam int PW = (DIV_REFRESH > 1) ? $clog2(DIV_REFRESH) : 1;

    // One-hot so each mode flag is a direct flop bit (ATAQUE ORs two bits)
    typedef enum logic [3:0] {
        S_OFF  = 4'b0001,
        S_PREP = 4'b0010,
        S_ATK  = 4'b0100,
        S_FIM  = 4'b1000
    } estado_t;

    estado_t        estado;
    logic           liga_prev;
    logic           conf_prev;
    logic [PW-1:0]  prescaler;
    logic [6:0]     acertos;
    logic [63:0]    atacadas;

    logic           liga_edge;
    logic           conf_edge;
    logic [5:0]     indice;

    assign liga_edge = botao_liga & ~liga_prev;
    assign conf_edge = botao_confirma & ~conf_prev;
    assign indice    = {coordLinha, coordColuna};

    assign DESLIGADO  = estado[0];
    assign PREPARACAO = estado[1];
    assign ATAQUE     = estado[2] | estado[3];

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            estado      <= S_OFF;
            liga_prev   <= 1'b0;
            conf_prev   <= 1'b0;
            prescaler   <= '0;
            contador    <= '0;
            coordColuna <= '0;
            coordLinha  <= '0;
            mapa        <= '0;
            vida        <= '0;
            vitoria     <= 1'b0;
            derrota     <= 1'b0;
            acertos     <= '0;
            atacadas    <= '0;
        end else begin
            liga_prev <= botao_liga;
            conf_prev <= botao_confirma;

            // Digit scan runs in every mode, independent of the FSM
            if (prescaler == PW'(DIV_REFRESH - 1)) begin
                prescaler <= '0;
                contador  <= contador + 2'd1;
            end else begin
                prescaler <= prescaler + 1'b1;
            end

            // Power edge has priority; a simultaneous confirm is discarded
            if (liga_edge) begin
                if (estado == S_OFF) begin
                    estado <= S_PREP;
                end else begin
                    estado      <= S_OFF;
                    coordColuna <= '0;
                    coordLinha  <= '0;
                    mapa        <= '0;
                    vida        <= '0;
                    vitoria     <= 1'b0;
                    derrota     <= 1'b0;
                end
            end else begin
                unique case (estado)
                    S_OFF: ;
                    S_PREP: begin
                        mapa <= chaves_mapa;
                        if (conf_edge) begin
                            estado   <= S_ATK;
                            vida     <= 3'(VIDA_INICIAL);
                            acertos  <= '0;
                            atacadas <= '0;
                            vitoria  <= 1'b0;
                            derrota  <= 1'b0;
                        end
                    end
                    S_ATK: begin
                        if (conf_edge) begin
                            // Cell is judged on the registered coordinates,
                            // which hold during the confirm cycle
                            if (!atacadas[indice]) begin
                                atacadas[indice] <= 1'b1;
                                if (celula_ocupada) begin
                                    acertos <= acertos + 7'd1;
                                    if (acertos + 7'd1 == 7'(ALVOS)) begin
                                        estado  <= S_FIM;
                                        vitoria <= 1'b1;
                                    end
                                end else begin
                                    vida <= vida - 3'd1;
                                    if (vida == 3'd1) begin
                                        estado  <= S_FIM;
                                        derrota <= 1'b1;
                                    end
                                end
                            end
                        end else begin
                            coordColuna <= chaves_coluna;
                            coordLinha  <= chaves_linha;
                        end
                    end
                    S_FIM: begin
                        if (conf_edge) begin
                            estado  <= S_PREP;
                            vitoria <= 1'b0;
                            derrota <= 1'b0;
                        end
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_controle_jogo.sv
// tb_controle_jogo
// Scenario bench for controle_jogo. Each scenario is a table of per-cycle
// stimulus with the outputs expected after that cycle's clock edge; the
// expectation is queued as the stimulus is driven and popped for comparison
// once the edge has happened.
module tb_controle_jogo;

    localparam int DIV = 4;
    localparam int VI  = 5;
    localparam int ALV = 2;

    localparam logic [2:0] M_OFF  = 3'b100;
    localparam logic [2:0] M_PREP = 3'b010;
    localparam logic [2:0] M_ATK  = 3'b001;

    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic       botao_liga = 1'b0;
    logic       botao_confirma = 1'b0;
    logic [2:0] chaves_coluna = '0;
    logic [2:0] chaves_linha = '0;
    logic [1:0] chaves_mapa = '0;
    logic       celula_ocupada;
    logic [1:0] contador;
    logic       ATAQUE, PREPARACAO, DESLIGADO;
    logic [2:0] coordColuna, coordLinha;
    logic [1:0] mapa;
    logic [2:0] vida;
    logic       vitoria, derrota;

    logic [63:0] navios = '0;

    controle_jogo #(
        .DIV_REFRESH (DIV),
        .VIDA_INICIAL(VI),
        .ALVOS       (ALV)
    ) dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .botao_liga    (botao_liga),
        .botao_confirma(botao_confirma),
        .chaves_coluna (chaves_coluna),
        .chaves_linha  (chaves_linha),
        .chaves_mapa   (chaves_mapa),
        .celula_ocupada(celula_ocupada),
        .contador      (contador),
        .ATAQUE        (ATAQUE),
        .PREPARACAO    (PREPARACAO),
        .DESLIGADO     (DESLIGADO),
        .coordColuna   (coordColuna),
        .coordLinha    (coordLinha),
        .mapa          (mapa),
        .vida          (vida),
        .vitoria       (vitoria),
        .derrota       (derrota)
    );

    // External map lookup driven by the registered coordinates
    assign celula_ocupada = navios[{coordLinha, coordColuna}];

    always #5 clock = ~clock;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [15:0] exp_q[$];
    logic [1:0]  cnt_q[$];

    typedef struct {
        logic        liga;
        logic        conf;
        logic [1:0]  msw;
        logic [2:0]  lin;
        logic [2:0]  col;
        logic [15:0] want;
    } step_t;

    // {DESLIGADO,PREPARACAO,ATAQUE, mapa, vida, vitoria, derrota, linha, coluna}
    function automatic logic [15:0] obs();
        return {DESLIGADO, PREPARACAO, ATAQUE, mapa, vida, vitoria, derrota,
                coordLinha, coordColuna};
    endfunction

    function automatic logic [15:0] ev(logic [2:0] m, logic [1:0] mp,
                                       logic [2:0] v, logic vt, logic dr,
                                       logic [2:0] l, logic [2:0] c);
        return {m, mp, v, vt, dr, l, c};
    endfunction

    function automatic step_t st(logic liga, logic conf, logic [1:0] msw,
                                 logic [2:0] lin, logic [2:0] col,
                                 logic [15:0] want);
        step_t s;
        s.liga = liga; s.conf = conf; s.msw = msw;
        s.lin = lin; s.col = col; s.want = want;
        return s;
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input step_t s);
        botao_liga     = s.liga;
        botao_confirma = s.conf;
        chaves_mapa    = s.msw;
        chaves_linha   = s.lin;
        chaves_coluna  = s.col;
    endtask

    task automatic test_reset();
        logic [15:0] got;
        logic [1:0]  want_c;
        repeat (3) @(posedge clock);
        #1 reset_n = 1'b1;
        n_cmp++;
        if (obs() !== ev(M_OFF, 0, 0, 0, 0, 0, 0) || contador !== 2'd0) begin
            n_fail++;
            $display("FAIL reset_state got=%h/%0d want=%h/0", obs(),
                     contador, ev(M_OFF, 0, 0, 0, 0, 0, 0));
        end
        for (int k = 1; k <= 16; k++) begin
            cnt_q.push_back(2'((k / DIV) % 4));
            exp_q.push_back(ev(M_OFF, 0, 0, 0, 0, 0, 0));
            tick();
            want_c = cnt_q.pop_front();
            got    = exp_q.pop_front();
            n_cmp++;
            if (contador !== want_c || obs() !== got) begin
                n_fail++;
                $display("FAIL idle_scan cycle %0d got cnt=%0d st=%h want cnt=%0d st=%h",
                         k, contador, obs(), want_c, got);
            end
        end
    endtask

    task automatic test_prep_map();
        step_t s[$];
        logic [15:0] want;
        s.push_back(st(1, 0, 2, 0, 0, ev(M_PREP, 0, 0, 0, 0, 0, 0)));
        s.push_back(st(0, 0, 2, 0, 0, ev(M_PREP, 2, 0, 0, 0, 0, 0)));
        s.push_back(st(0, 1, 2, 0, 0, ev(M_ATK, 2, 5, 0, 0, 0, 0)));
        s.push_back(st(0, 0, 1, 0, 0, ev(M_ATK, 2, 5, 0, 0, 0, 0)));
        s.push_back(st(0, 0, 1, 0, 0, ev(M_ATK, 2, 5, 0, 0, 0, 0)));
        foreach (s[k]) begin
            drive(s[k]);
            exp_q.push_back(s[k].want);
            tick();
            want = exp_q.pop_front();
            n_cmp++;
            if (obs() !== want) begin
                n_fail++;
                $display("FAIL prep_map step %0d got=%h want=%h", k, obs(), want);
            end
        end
    endtask

    task automatic test_lives();
        step_t s[$];
        logic [15:0] want;
        navios = '0;
        s.push_back(st(0, 0, 1, 3, 4, ev(M_ATK, 2, 5, 0, 0, 3, 4)));
        s.push_back(st(0, 1, 1, 7, 0, ev(M_ATK, 2, 4, 0, 0, 3, 4)));
        s.push_back(st(0, 0, 1, 3, 4, ev(M_ATK, 2, 4, 0, 0, 3, 4)));
        s.push_back(st(0, 1, 1, 3, 4, ev(M_ATK, 2, 4, 0, 0, 3, 4)));
        s.push_back(st(0, 0, 1, 0, 1, ev(M_ATK, 2, 4, 0, 0, 0, 1)));
        s.push_back(st(0, 1, 1, 6, 6, ev(M_ATK, 2, 3, 0, 0, 0, 1)));
        s.push_back(st(0, 0, 1, 0, 2, ev(M_ATK, 2, 3, 0, 0, 0, 2)));
        s.push_back(st(0, 1, 1, 0, 2, ev(M_ATK, 2, 2, 0, 0, 0, 2)));
        s.push_back(st(0, 0, 1, 0, 3, ev(M_ATK, 2, 2, 0, 0, 0, 3)));
        s.push_back(st(0, 1, 1, 0, 3, ev(M_ATK, 2, 1, 0, 0, 0, 3)));
        s.push_back(st(0, 0, 1, 0, 4, ev(M_ATK, 2, 1, 0, 0, 0, 4)));
        s.push_back(st(0, 1, 1, 0, 4, ev(M_ATK, 2, 0, 0, 1, 0, 4)));
        s.push_back(st(0, 0, 1, 5, 5, ev(M_ATK, 2, 0, 0, 1, 0, 4)));
        s.push_back(st(0, 1, 1, 5, 5, ev(M_PREP, 2, 0, 0, 0, 0, 4)));
        s.push_back(st(0, 0, 1, 5, 5, ev(M_PREP, 1, 0, 0, 0, 0, 4)));
        foreach (s[k]) begin
            drive(s[k]);
            exp_q.push_back(s[k].want);
            tick();
            want = exp_q.pop_front();
            n_cmp++;
            if (obs() !== want) begin
                n_fail++;
                $display("FAIL lives step %0d got=%h want=%h", k, obs(), want);
            end
        end
    endtask

    task automatic test_win();
        step_t s[$];
        logic [15:0] want;
        navios = '0;
        navios[0]  = 1'b1;
        navios[63] = 1'b1;
        s.push_back(st(0, 1, 1, 0, 0, ev(M_ATK, 1, 5, 0, 0, 0, 4)));
        s.push_back(st(0, 0, 1, 0, 0, ev(M_ATK, 1, 5, 0, 0, 0, 0)));
        s.push_back(st(0, 1, 1, 0, 0, ev(M_ATK, 1, 5, 0, 0, 0, 0)));
        s.push_back(st(0, 0, 1, 0, 0, ev(M_ATK, 1, 5, 0, 0, 0, 0)));
        s.push_back(st(0, 1, 1, 0, 0, ev(M_ATK, 1, 5, 0, 0, 0, 0)));
        s.push_back(st(0, 0, 1, 7, 7, ev(M_ATK, 1, 5, 0, 0, 7, 7)));
        s.push_back(st(0, 1, 1, 7, 7, ev(M_ATK, 1, 5, 1, 0, 7, 7)));
        s.push_back(st(0, 0, 1, 2, 3, ev(M_ATK, 1, 5, 1, 0, 7, 7)));
        foreach (s[k]) begin
            drive(s[k]);
            exp_q.push_back(s[k].want);
            tick();
            want = exp_q.pop_front();
            n_cmp++;
            if (obs() !== want) begin
                n_fail++;
                $display("FAIL win step %0d got=%h want=%h", k, obs(), want);
            end
        end
    endtask

    task automatic test_hold_confirm();
        step_t s[$];
        logic [15:0] want;
        s.push_back(st(0, 1, 1, 7, 7, ev(M_PREP, 1, 5, 0, 0, 7, 7)));
        s.push_back(st(0, 0, 1, 7, 7, ev(M_PREP, 1, 5, 0, 0, 7, 7)));
        s.push_back(st(0, 1, 1, 7, 7, ev(M_ATK, 1, 5, 0, 0, 7, 7)));
        s.push_back(st(0, 0, 1, 2, 2, ev(M_ATK, 1, 5, 0, 0, 2, 2)));
        for (int k = 0; k < 20; k++)
            s.push_back(st(0, 1, 1, 2, 2, ev(M_ATK, 1, 4, 0, 0, 2, 2)));
        s.push_back(st(0, 0, 1, 2, 2, ev(M_ATK, 1, 4, 0, 0, 2, 2)));
        foreach (s[k]) begin
            drive(s[k]);
            exp_q.push_back(s[k].want);
            tick();
            want = exp_q.pop_front();
            n_cmp++;
            if (obs() !== want) begin
                n_fail++;
                $display("FAIL hold_confirm step %0d got=%h want=%h", k, obs(), want);
            end
        end
    endtask

    task automatic test_liga_confirm();
        step_t s[$];
        logic [15:0] want;
        s.push_back(st(1, 1, 1, 1, 1, ev(M_OFF, 0, 0, 0, 0, 0, 0)));
        s.push_back(st(0, 0, 1, 1, 1, ev(M_OFF, 0, 0, 0, 0, 0, 0)));
        s.push_back(st(0, 1, 1, 1, 1, ev(M_OFF, 0, 0, 0, 0, 0, 0)));
        s.push_back(st(0, 0, 1, 1, 1, ev(M_OFF, 0, 0, 0, 0, 0, 0)));
        foreach (s[k]) begin
            drive(s[k]);
            exp_q.push_back(s[k].want);
            tick();
            want = exp_q.pop_front();
            n_cmp++;
            if (obs() !== want) begin
                n_fail++;
                $display("FAIL liga_confirm step %0d got=%h want=%h", k, obs(), want);
            end
        end
    endtask

    task automatic test_async_reset();
        step_t s[$];
        logic [15:0] want;
        s.push_back(st(1, 0, 3, 0, 0, ev(M_PREP, 0, 0, 0, 0, 0, 0)));
        s.push_back(st(0, 0, 3, 0, 0, ev(M_PREP, 3, 0, 0, 0, 0, 0)));
        s.push_back(st(0, 1, 3, 0, 0, ev(M_ATK, 3, 5, 0, 0, 0, 0)));
        s.push_back(st(0, 0, 3, 5, 6, ev(M_ATK, 3, 5, 0, 0, 5, 6)));
        foreach (s[k]) begin
            drive(s[k]);
            exp_q.push_back(s[k].want);
            tick();
            want = exp_q.pop_front();
            n_cmp++;
            if (obs() !== want) begin
                n_fail++;
                $display("FAIL async_setup step %0d got=%h want=%h", k, obs(), want);
            end
        end
        // Assert reset between edges and look before any further edge
        @(posedge clock);
        #3 reset_n = 1'b0;
        exp_q.push_back(ev(M_OFF, 0, 0, 0, 0, 0, 0));
        cnt_q.push_back(2'd0);
        #1;
        want = exp_q.pop_front();
        n_cmp++;
        if (obs() !== want || contador !== cnt_q.pop_front()) begin
            n_fail++;
            $display("FAIL async_reset got=%h cnt=%0d want=%h cnt=0",
                     obs(), contador, want);
        end
        repeat (2) tick();
        reset_n = 1'b1;
        exp_q.push_back(ev(M_OFF, 0, 0, 0, 0, 0, 0));
        tick();
        want = exp_q.pop_front();
        n_cmp++;
        if (obs() !== want) begin
            n_fail++;
            $display("FAIL reset_release got=%h want=%h", obs(), want);
        end
    endtask

    initial begin
        test_reset();
        test_prep_map();
        test_lives();
        test_win();
        test_hold_confirm();
        test_liga_confirm();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
